// File: rtl/eth_link_supervisor.sv
// eth_link_supervisor: bring-up and recovery sequencer for the 10G QSFP port.
// Holds the GT wizard in full reset, waits for GT reset-done and PHY block
// lock, declares link up/down with debounce, and escalates from RX datapath
// resets to full resets when lock never arrives.
// Optional build macro ETH_LINK_SUPERVISOR_STATS_EN adds saturating
// link-down and full-reset event counters; without it both read as zero.
module eth_link_supervisor #(
    parameter int RESET_CYCLES        = 1024,
    parameter int RX_RESET_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 12500000,
    parameter int DEBOUNCE_CYCLES     = 1250,
    parameter int MAX_RX_RETRIES      = 4,
    parameter int CNT_WIDTH           = 24
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        gt_reset_tx_done,
    input  logic        gt_reset_rx_done,
    input  logic        rx_block_lock,
    input  logic        rx_high_ber,
    input  logic        qsfp_modprsl,
    input  logic        force_reset,
    output logic        gt_reset_all,
    output logic        gt_reset_rx_datapath,
    output logic        link_up,
    output logic [2:0]  state,
    output logic [2:0]  retry_count,
    output logic [15:0] link_down_count,
    output logic [15:0] full_reset_count
);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_GT   = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_UP        = 3'd3,
        S_RX_RESET  = 3'd4,
        S_ABSENT    = 3'd5
    } state_e;

    // Terminal counts: a state that waits N cycles exits when timer == N-1.
    localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] RESET_LAST = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RX_LAST    = CNT_WIDTH'(RX_RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST    = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DEB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]           MAX_RETRY  = 3'(MAX_RX_RETRIES);

    // Synchronizer bit order: {modprsl, high_ber, block_lock, rx_done, tx_done}.
    // modprsl resets to 1 so the module reads as absent until proven present.
    localparam logic [4:0] SYNC_RST = 5'b10000;

    logic [4:0]           sync1_q, sync2_q;
    logic                 tx_done_s, rx_done_s, lock_s, ber_s, modprsl_s;
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] timer_q, timer_d;
    logic [CNT_WIDTH-1:0] deb_q, deb_d;
    logic [2:0]           retry_q, retry_d;
    logic                 gt_reset_all_q, rx_dp_q, link_up_q;
    logic                 restart, changed, gt_done, good;

    // Two-flop synchronizers for every asynchronous / rx_clk-domain input.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
        end else begin
            sync1_q <= {qsfp_modprsl, rx_high_ber, rx_block_lock,
                        gt_reset_rx_done, gt_reset_tx_done};
            sync2_q <= sync1_q;
        end
    end

    assign tx_done_s = sync2_q[0];
    assign rx_done_s = sync2_q[1];
    assign lock_s    = sync2_q[2];
    assign ber_s     = sync2_q[3];
    assign modprsl_s = sync2_q[4];
    assign gt_done   = tx_done_s & rx_done_s;
    assign good      = lock_s & ~ber_s;

    // Next-state, timer, debounce and retry bookkeeping.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + ONE;
        deb_d   = '0;
        retry_d = retry_q;
        restart = 1'b0;
        if (modprsl_s) begin
            state_d = S_ABSENT;
        end else if (force_reset) begin
            // A forced reset always restarts the reset window, even from S_RESET.
            state_d = S_RESET;
            restart = 1'b1;
        end else begin
            case (state_q)
                S_RESET: begin
                    if (timer_q == RESET_LAST) state_d = S_WAIT_GT;
                end
                S_WAIT_GT: begin
                    if (gt_done)                  state_d = S_WAIT_LOCK;
                    else if (timer_q == TO_LAST)  state_d = S_RESET;
                end
                S_WAIT_LOCK: begin
                    // Debounce completion wins over a coincident timeout.
                    if (good && deb_q == DEB_LAST)  state_d = S_UP;
                    else if (timer_q == TO_LAST)    state_d = (retry_q < MAX_RETRY) ? S_RX_RESET : S_RESET;
                    else if (good)                  deb_d = deb_q + ONE;
                end
                S_RX_RESET: begin
                    if (timer_q == RX_LAST) state_d = S_WAIT_GT;
                end
                S_UP: begin
                    if (!gt_done)                     state_d = S_WAIT_GT;
                    else if (!good && deb_q == DEB_LAST) state_d = S_WAIT_LOCK;
                    else if (!good)                   deb_d = deb_q + ONE;
                end
                S_ABSENT: begin
                    state_d = S_RESET;
                end
                default: begin
                    state_d = S_RESET;
                end
            endcase
        end

        changed = (state_d != state_q) || restart;
        if (changed) begin
            timer_d = '0;
            deb_d   = '0;
        end

        // Retries count RX datapath resets since the last full reset or link-up.
        if (changed && state_d == S_RESET)                   retry_d = '0;
        else if (state_d == S_UP && state_q != S_UP)         retry_d = '0;
        else if (state_q == S_WAIT_LOCK && state_d == S_RX_RESET) retry_d = retry_q + 3'd1;
    end

    // FSM register with registered outputs; link_up lags S_UP by one cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_RESET;
            timer_q        <= '0;
            deb_q          <= '0;
            retry_q        <= '0;
            gt_reset_all_q <= 1'b1;
            rx_dp_q        <= 1'b0;
            link_up_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            deb_q          <= deb_d;
            retry_q        <= retry_d;
            gt_reset_all_q <= (state_d == S_RESET) || (state_d == S_ABSENT);
            rx_dp_q        <= (state_d == S_RX_RESET);
            link_up_q      <= (state_q == S_UP);
        end
    end

    assign state                = state_q;
    assign retry_count          = retry_q;
    assign gt_reset_all         = gt_reset_all_q;
    assign gt_reset_rx_datapath = rx_dp_q;
    assign link_up              = link_up_q;

`ifdef ETH_LINK_SUPERVISOR_STATS_EN
    logic [15:0] link_down_q, full_reset_q;

    // Saturating event counters; only resetn clears them.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            link_down_q  <= '0;
            full_reset_q <= '0;
        end else begin
            if (state_q == S_UP && state_d != S_UP && link_down_q != 16'hFFFF)
                link_down_q <= link_down_q + 16'd1;
            if (changed && state_d == S_RESET && full_reset_q != 16'hFFFF)
                full_reset_q <= full_reset_q + 16'd1;
        end
    end

    assign link_down_count  = link_down_q;
    assign full_reset_count = full_reset_q;
`else
    assign link_down_count  = '0;
    assign full_reset_count = '0;
`endif

endmodule

// File: tb/tb_eth_link_supervisor.sv
// tb_eth_link_supervisor: directed bring-up/recovery scenarios followed by
// randomized input traffic, checked cycle by cycle against a reference model
// built from input history, time-since-entry stamps and run lengths.
module tb_eth_link_supervisor;

  localparam int RST_N  = 8;
  localparam int RXR_N  = 16;
  localparam int TO_N   = 64;
  localparam int DEB_N  = 4;
  localparam int MAX_R  = 4;
  localparam int MAXC   = 8192;
  localparam int W      = 41;

  localparam int B_TX = 0, B_RX = 1, B_LOCK = 2, B_BER = 3, B_MOD = 4, B_FORCE = 5;

`ifdef ETH_LINK_SUPERVISOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic tx = 1'b0, rx = 1'b0, lock = 1'b0, ber = 1'b0, mod = 1'b0, force_r = 1'b0;
  logic        gt_reset_all, gt_reset_rx_datapath, link_up;
  logic [2:0]  state, retry_count;
  logic [15:0] link_down_count, full_reset_count;

  always #5 clock = ~clock;

  eth_link_supervisor #(
    .RESET_CYCLES(RST_N), .RX_RESET_CYCLES(RXR_N), .LOCK_TIMEOUT_CYCLES(TO_N),
    .DEBOUNCE_CYCLES(DEB_N), .MAX_RX_RETRIES(MAX_R), .CNT_WIDTH(24)
  ) dut (
    .clock(clock), .resetn(resetn),
    .gt_reset_tx_done(tx), .gt_reset_rx_done(rx),
    .rx_block_lock(lock), .rx_high_ber(ber),
    .qsfp_modprsl(mod), .force_reset(force_r),
    .gt_reset_all(gt_reset_all), .gt_reset_rx_datapath(gt_reset_rx_datapath),
    .link_up(link_up), .state(state), .retry_count(retry_count),
    .link_down_count(link_down_count), .full_reset_count(full_reset_count)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [5:0] hist [0:MAXC-1];
  int edge_n = 0;
  int m_state = 0, m_enter = 0, m_retry = 0, m_ldc = 0, m_frc = 0, m_rst_last = 0;

  // Value the DUT logic sees at edge t: input from two edges earlier, or the
  // synchronizer reset value while the flops are still refilling after reset.
  function automatic logic syncd(int t, int b);
    if (t - m_rst_last >= 3) return hist[t-2][b];
    return (b == B_MOD) ? 1'b1 : 1'b0;
  endfunction

  // True when the last DEB_N edges, all inside the current state, saw lock
  // quality equal to want_good.
  function automatic logic deb_ok(int t, logic want_good);
    for (int k = 0; k < DEB_N; k++) begin
      if (t - k <= m_enter) return 1'b0;
      if ((syncd(t - k, B_LOCK) & ~syncd(t - k, B_BER)) != want_good) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] pack_exp(int st, logic lu, int rc, int ldc, int frc);
    logic [15:0] l16, f16;
    l16 = STATS ? 16'(ldc) : 16'd0;
    f16 = STATS ? 16'(frc) : 16'd0;
    return {3'(st), logic'(st == 0 || st == 5), logic'(st == 4), lu, 3'(rc), l16, f16};
  endfunction

  function automatic void model_step(int t, logic rstn);
    int cur, nxt, d;
    logic sm, f, dn, entry;
    cur = m_state;
    if (!rstn) begin
      m_state = 0; m_retry = 0; m_ldc = 0; m_frc = 0;
      m_rst_last = t; m_enter = t;
      exp_q.push_back(pack_exp(0, 1'b0, 0, 0, 0));
      return;
    end
    sm = syncd(t, B_MOD);
    f  = hist[t][B_FORCE];
    dn = syncd(t, B_TX) & syncd(t, B_RX);
    d  = t - m_enter;
    nxt = cur;
    entry = 1'b0;
    if (sm) nxt = 5;
    else if (f) begin nxt = 0; entry = 1'b1; end
    else begin
      case (cur)
        0: if (d == RST_N) nxt = 1;
        1: if (dn) nxt = 2; else if (d == TO_N) nxt = 0;
        2: if (deb_ok(t, 1'b1)) nxt = 3;
           else if (d == TO_N) nxt = (m_retry < MAX_R) ? 4 : 0;
        4: if (d == RXR_N) nxt = 1;
        3: if (!dn) nxt = 1; else if (deb_ok(t, 1'b0)) nxt = 2;
        default: nxt = 0;
      endcase
    end
    if (nxt != cur) entry = 1'b1;
    if (entry && nxt == 0) begin
      m_retry = 0;
      if (m_frc < 65535) m_frc++;
    end
    if (nxt == 3 && cur != 3) m_retry = 0;
    if (cur == 2 && nxt == 4) m_retry++;
    if (cur == 3 && nxt != 3 && m_ldc < 65535) m_ldc++;
    if (entry) m_enter = t;
    m_state = nxt;
    exp_q.push_back(pack_exp(nxt, logic'(cur == 3), m_retry, m_ldc, m_frc));
  endfunction

  // ---------------- driver tasks ----------------
  logic [5:0] cur_v = '0;

  task automatic drive(input logic [5:0] v, input logic rstn);
    logic prev;
    @(negedge clock);
    prev = resetn;
    tx = v[B_TX]; rx = v[B_RX]; lock = v[B_LOCK];
    ber = v[B_BER]; mod = v[B_MOD]; force_r = v[B_FORCE];
    resetn = rstn;
    edge_n++;
    if (edge_n >= MAXC) begin
      $display("FAIL edge_budget: got %0d edges, limit %0d", edge_n, MAXC);
      $fatal(1, "edge budget exceeded");
    end
    hist[edge_n] = v;
    model_step(edge_n, rstn);
    if (prev && !rstn) begin
      // Asynchronous reset must take effect before the next clock edge.
      #1;
      check("async_rst_state", int'(state), 0);
      check("async_rst_gt_reset_all", int'(gt_reset_all), 1);
      check("async_rst_rx_datapath", int'(gt_reset_rx_datapath), 0);
      check("async_rst_link_up", int'(link_up), 0);
      check("async_rst_retry", int'(retry_count), 0);
      check("async_rst_link_down_count", int'(link_down_count), 0);
      check("async_rst_full_reset_count", int'(full_reset_count), 0);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) drive(cur_v, 1'b1);
  endtask

  task automatic pulse_force();
    drive(cur_v | 6'b100000, 1'b1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",            int'(state),                e[40:38]);
        check("gt_reset_all",     int'(gt_reset_all),         e[37]);
        check("rx_datapath",      int'(gt_reset_rx_datapath), e[36]);
        check("link_up",          int'(link_up),              e[35]);
        check("retry_count",      int'(retry_count),          e[34:32]);
        check("link_down_count",  int'(link_down_count),      e[31:16]);
        check("full_reset_count", int'(full_reset_count),     e[15:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] v;
    int rst_hold;
    int waited;
    rst_hold = 0;

    repeat (3) drive(6'b0, 1'b0);

    // Bring-up: done arrives later, then lock.
    hold(17);
    cur_v[B_TX] = 1'b1; cur_v[B_RX] = 1'b1;
    hold(10);
    cur_v[B_LOCK] = 1'b1;
    hold(20);

    // Short lock glitch stays up; long loss drops link, then recovers.
    cur_v[B_LOCK] = 1'b0; hold(2);
    cur_v[B_LOCK] = 1'b1; hold(10);
    cur_v[B_LOCK] = 1'b0; hold(5);
    cur_v[B_LOCK] = 1'b1; hold(15);

    // High-BER pulse in the middle of the lock debounce.
    cur_v[B_LOCK] = 1'b0; hold(6);
    cur_v[B_LOCK] = 1'b1; hold(2);
    cur_v[B_BER] = 1'b1; hold(1);
    cur_v[B_BER] = 1'b0; hold(12);

    // Module pulled while up, then reinserted.
    cur_v[B_MOD] = 1'b1; hold(5);
    cur_v[B_MOD] = 1'b0; hold(30);

    // Forced full reset from S_UP.
    pulse_force();
    hold(30);

    // Loss of GT done while up.
    cur_v[B_RX] = 1'b0; hold(3);
    cur_v[B_RX] = 1'b1; hold(12);

    // Lock never arrives: RX retries escalate to a full reset.
    cur_v[B_LOCK] = 1'b0; hold(430);
    cur_v[B_LOCK] = 1'b1; hold(40);

    // Reset asserted in the middle of an RX datapath reset pulse.
    cur_v[B_LOCK] = 1'b0;
    waited = 0;
    while (m_state != 4 && waited < 300) begin hold(1); waited++; end
    hold(5);
    check("rx_reset_entered", int'(state), 4);
    repeat (3) drive(cur_v, 1'b0);
    cur_v[B_LOCK] = 1'b1;
    hold(40);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) cur_v[B_LOCK] = ~cur_v[B_LOCK];
      cur_v[B_BER] = ($urandom_range(0, 79) == 0) ? 1'b1 : (cur_v[B_BER] && $urandom_range(0, 3) != 0);
      if (cur_v[B_TX]) begin if ($urandom_range(0, 399) == 0) cur_v[B_TX] = 1'b0; end
      else if ($urandom_range(0, 19) == 0) cur_v[B_TX] = 1'b1;
      if (cur_v[B_RX]) begin if ($urandom_range(0, 399) == 0) cur_v[B_RX] = 1'b0; end
      else if ($urandom_range(0, 19) == 0) cur_v[B_RX] = 1'b1;
      if (cur_v[B_MOD]) begin if ($urandom_range(0, 9) == 0) cur_v[B_MOD] = 1'b0; end
      else if ($urandom_range(0, 999) == 0) cur_v[B_MOD] = 1'b1;
      v = cur_v;
      if ($urandom_range(0, 699) == 0) v[B_FORCE] = 1'b1;
      if (rst_hold == 0 && $urandom_range(0, 1499) == 0) rst_hold = $urandom_range(1, 3);
      if (rst_hold > 0) begin
        drive(v, 1'b0);
        rst_hold--;
      end else begin
        drive(v, 1'b1);
      end
    end

    hold(2);
    @(posedge clock);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eth_link_supervisor.md
Name:
eth_link_supervisor

Overview:
- Link bring-up and recovery sequencer for the 10G QSFP port: GT wizard, 10G PHY and MAC FIFO.
- Runs on the free-running 125 MHz clock.
- Drives the GT wizard full reset and the RX datapath reset.
- Monitors GT reset-done, PHY block lock, high BER and QSFP module presence; declares link up/down and retries escalating resets on failure.
- Replaces the fixed power-on reset timer with a supervised state machine.

Parameters:
- RESET_CYCLES, 1024: cycles gt_reset_all is held in S_RESET.
- RX_RESET_CYCLES, 16: width of the gt_reset_rx_datapath pulse.
- LOCK_TIMEOUT_CYCLES, 12500000: max cycles in S_WAIT_GT or S_WAIT_LOCK (100 ms).
- DEBOUNCE_CYCLES, 1250: cycles lock must be stably good to go up, or stably bad to go down.
- MAX_RX_RETRIES, 4: RX datapath resets before escalating to full reset.
- CNT_WIDTH, 24: timer width; must hold the largest cycle parameter.

Ports:
- clock  in  1  free-running 125 MHz clock
- resetn  in  1  asynchronous active-low reset
- gt_reset_tx_done  in  1  GT wizard TX reset done (async)
- gt_reset_rx_done  in  1  GT wizard RX reset done (async)
- rx_block_lock  in  1  PHY block lock (rx_clk domain)
- rx_high_ber  in  1  PHY high BER (rx_clk domain)
- qsfp_modprsl  in  1  module present, active-low (async)
- force_reset  in  1  single-cycle request for a full reset (clock domain)
- gt_reset_all  out  1  to gtwiz_reset_all_in
- gt_reset_rx_datapath  out  1  to gtwiz_reset_rx_datapath_in
- link_up  out  1  link status
- state  out  3  current FSM state code
- retry_count  out  3  RX retries since last full reset
- link_down_count  out  16  see Optional Feature
- full_reset_count  out  16  see Optional Feature

Behaviour:
- Synchronizers: every async/foreign input passes a 2-flop synchronizer, giving 2 cycles of latency. Synchronizer flops reset to 0, except modprsl, which resets to 1 (absent). All logic below uses the synchronized values.
- Reset values (async, resetn=0): state=S_RESET(0), gt_reset_all=1, gt_reset_rx_datapath=0, link_up=0, timer=0, retry_count=0, counters=0.
- States and transitions:
  - S_RESET(0): gt_reset_all=1. After RESET_CYCLES cycles go to S_WAIT_GT and clear the timer.
  - S_WAIT_GT(1): tx_done&&rx_done goes to S_WAIT_LOCK. On timeout go to S_RESET and clear retry_count.
  - S_WAIT_LOCK(2): the debounce counter increments while lock=1 and high_ber=0, and clears otherwise.
    - Reaching DEBOUNCE_CYCLES goes to S_UP and clears retry_count.
    - On timeout: if retry_count<MAX_RX_RETRIES, go to S_RX_RESET and increment retry_count; otherwise go to S_RESET and clear retry_count.
  - S_RX_RESET(4): gt_reset_rx_datapath=1 for exactly RX_RESET_CYCLES cycles, then go to S_WAIT_GT.
  - S_UP(3): link_up=1, registered, so it rises 1 cycle after entry.
    - The bad counter increments while lock=0 or high_ber=1, and clears when good.
    - Reaching DEBOUNCE_CYCLES goes to S_WAIT_LOCK.
    - Loss of tx_done or rx_done goes to S_WAIT_GT immediately.
  - S_ABSENT(5): gt_reset_all=1, link_up=0. Synchronized modprsl=0 goes to S_RESET.
- Global priority, evaluated every cycle:
  1. modprsl=1 → S_ABSENT.
  2. force_reset → S_RESET.
  3. State-local transitions.
- Timers: a single CNT_WIDTH timer clears on every state change. Terminal comparison is timer==N-1, so a state lasts exactly N cycles.
- Outputs:
  - link_up deasserts the cycle after S_UP is left.
  - state is registered.
  - gt_reset_all is 1 in S_RESET and S_ABSENT, else 0.
  - gt_reset_rx_datapath is 1 only in S_RX_RESET.
- Reset mid-operation: resetn assertion immediately forces reset values, including ending any RX reset pulse early.

Optional Feature:
- Macro: ETH_LINK_SUPERVISOR_STATS_EN.
- When defined:
  - link_down_count increments on each S_UP→non-S_UP transition.
  - full_reset_count increments on each entry to S_RESET, excluding the reset-release entry.
  - Both are 16-bit, saturate at 0xFFFF and clear only on resetn.
- When undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
1. Bring-up. Params RESET=8, DEBOUNCE=4, TIMEOUT=64, RX_RESET=16. Release resetn; gt_reset_all falls after 8 cycles. Assert done at cycle 20 and lock at cycle 30 → link_up=1 at cycle 37 (2 sync + 4 debounce + 1 register), state=3.
2. Lock never arrives → gt_reset_rx_datapath pulses 16 cycles after each 64-cycle timeout, retry_count reaches 1..4. Fifth timeout → gt_reset_all=1, state=0, retry_count=0, full_reset_count=1 (STATS_EN).
3. In S_UP, lock low for 2 cycles → link_up stays 1. Lock low for 5 cycles → link_up=0, state=2, link_down_count=1.
4. In S_UP, modprsl=1 → within 3 cycles state=5, gt_reset_all=1, link_up=0. Then modprsl=0 → S_RESET held 8 cycles, then full bring-up.
5. high_ber pulse mid-debounce in S_WAIT_LOCK → debounce restarts; link_up is delayed by the full 4 cycles after high_ber clears.
6. resetn asserted mid-S_RX_RESET → gt_reset_rx_datapath=0 and gt_reset_all=1 in the same cycle, all counters 0. force_reset in S_UP → state=0 next cycle.
